// File: rtl/scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard_unit
//
// Decode-stage hazard unit for a 5-stage pipeline with a variable-latency data
// memory. A one-bit-per-register scoreboard records destinations of loads in
// flight, and a small counter tracks how many loads are outstanding. From these
// and the instruction held in IF/ID it produces the IF/ID stall / pcWrite
// controls and the issue strobe into ID/EX. It also keeps the branch/JALR RAW
// interlock against the instruction in EX, a saturating stall-cycle counter and
// a sticky protocol-error flag.
//
// Ports
//   i_clk            pipeline clock
//   i_rst_n          asynchronous active-low reset
//   i_instr          instruction held in IF/ID
//   i_instr_valid    IF/ID holds a real instruction
//   i_flush          taken branch/jump, IF/ID is killed this cycle
//   i_id_ex_regWrite instruction in EX writes a register
//   i_id_ex_rd       EX destination register
//   i_ld_done        a load completes (data forwardable) this cycle
//   i_ld_rd          destination of the completing load
//   o_stall          hold PC and IF/ID (combinational)
//   o_pcWrite        ~o_stall
//   o_issue          IF/ID instruction enters ID/EX this cycle (combinational)
//   o_busy_vec       registered scoreboard
//   o_outstanding    registered number of loads in flight
//   o_stall_cycles   saturating count of stalled cycles
//   o_err            sticky: load completion seen with nothing outstanding
// -----------------------------------------------------------------------------
module scoreboard_hazard_unit #(
   parameter int NUM_REGS        = 32,
   parameter int REG_W           = $clog2(NUM_REGS),
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [31:0]         i_instr,
   input  logic                i_instr_valid,
   input  logic                i_flush,
   input  logic                i_id_ex_regWrite,
   input  logic [REG_W-1:0]    i_id_ex_rd,
   input  logic                i_ld_done,
   input  logic [REG_W-1:0]    i_ld_rd,
   output logic                o_stall,
   output logic                o_pcWrite,
   output logic                o_issue,
   output logic [NUM_REGS-1:0] o_busy_vec,
   output logic [2:0]          o_outstanding,
   output logic [CNT_W-1:0]    o_stall_cycles,
   output logic                o_err
);

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [NUM_REGS-1:0] r_busy_vec;
   logic [2:0]          r_outstanding;
   logic [CNT_W-1:0]    r_stall_cycles;
   logic                r_err;

   logic [6:0]          w_op;
   logic [REG_W-1:0]    w_rs1;
   logic [REG_W-1:0]    w_rs2;
   logic [REG_W-1:0]    w_rd;
   logic                w_use_rs1;
   logic                w_use_rs2;
   logic [NUM_REGS-1:0] w_done_dec;
   logic [NUM_REGS-1:0] w_set_dec;
   logic [NUM_REGS-1:0] w_busy_eff;
   logic [NUM_REGS-1:0] w_busy_next;
   logic                w_haz_a;
   logic                w_haz_b;
   logic                w_haz_c;
   logic                w_live;
   logic                w_stall;
   logic                w_issue;
   logic                w_load_issue;
   logic                w_done_ok;
   logic                w_err_evt;

   assign w_op  = i_instr[6:0];
   assign w_rs1 = i_instr[15 +: REG_W];
   assign w_rs2 = i_instr[20 +: REG_W];
   assign w_rd  = i_instr[7 +: REG_W];

   always_comb begin
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      case (w_op)
         OP_RTYPE, OP_STORE, OP_BRANCH: begin
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
         end
         OP_ITYPE, OP_LOAD, OP_JALR, OP_SYSTEM: w_use_rs1 = 1'b1;
         default: ;
      endcase
   end

   // Per-register decode of the completing load and of the issuing load's rd.
   // x0 is never marked busy.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi = gi + 1) begin : g_dec
         assign w_done_dec[gi] = i_ld_done & (i_ld_rd == REG_W'(gi));
         if (gi == 0) begin : g_x0
            assign w_set_dec[gi] = 1'b0;
         end else begin : g_xn
            assign w_set_dec[gi] = w_load_issue & (w_rd == REG_W'(gi));
         end
      end
   endgenerate

   // A load completing this cycle is bypassed, so its register no longer hazards.
   assign w_busy_eff = r_busy_vec & ~w_done_dec;

   assign w_haz_a = (w_use_rs1 & (w_rs1 != '0) & w_busy_eff[w_rs1]) |
                    (w_use_rs2 & (w_rs2 != '0) & w_busy_eff[w_rs2]);

   assign w_haz_b = ((w_op == OP_BRANCH) | (w_op == OP_JALR)) &
                    i_id_ex_regWrite & (i_id_ex_rd != '0) &
                    ((w_use_rs1 & (i_id_ex_rd == w_rs1)) |
                     (w_use_rs2 & (i_id_ex_rd == w_rs2)));

   // A completing load frees a slot in the same cycle, so capacity only blocks
   // when nothing retires.
   assign w_haz_c = (w_op == OP_LOAD) &
                    (r_outstanding == 3'(MAX_OUTSTANDING)) & ~i_ld_done;

   // Reset gates the combinational controls so the pipeline runs freely.
   assign w_live       = i_rst_n & i_instr_valid & ~i_flush;
   assign w_stall      = w_live & (w_haz_a | w_haz_b | w_haz_c);
   assign w_issue      = w_live & ~(w_haz_a | w_haz_b | w_haz_c);
   assign w_load_issue = w_issue & (w_op == OP_LOAD);

   // A completion with nothing outstanding is a protocol error and is ignored.
   assign w_done_ok = i_ld_done & (r_outstanding != 3'd0);
   assign w_err_evt = i_ld_done & (r_outstanding == 3'd0);

   // Clear first, then set: a load issuing to the register that is completing
   // keeps it busy.
   assign w_busy_next = (r_busy_vec & ~({NUM_REGS{w_done_ok}} & w_done_dec)) | w_set_dec;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy_vec     <= '0;
         r_outstanding  <= 3'd0;
         r_stall_cycles <= '0;
         r_err          <= 1'b0;
      end else begin
         r_busy_vec <= w_busy_next;
         case ({w_load_issue, w_done_ok})
            2'b10:   r_outstanding <= r_outstanding + 3'd1;
            2'b01:   r_outstanding <= r_outstanding - 3'd1;
            default: r_outstanding <= r_outstanding;
         endcase
         if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         if (w_err_evt) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_stall        = w_stall;
   assign o_pcWrite      = ~w_stall;
   assign o_issue        = w_issue;
   assign o_busy_vec     = r_busy_vec;
   assign o_outstanding  = r_outstanding;
   assign o_stall_cycles = r_stall_cycles;
   assign o_err          = r_err;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_hazard_unit
//
// Directed scenarios followed by randomized traffic. A behavioural model
// (array of busy flags, integer load count, integer stall count, error bit)
// predicts every output each cycle; a few literal expectations pin the model.
// The stall counter is built narrow so saturation is reached.
// -----------------------------------------------------------------------------
module tb_scoreboard_hazard_unit;

   localparam int NR = 32;
   localparam int RW = 5;
   localparam int MO = 2;
   localparam int CW = 5;
   localparam int CNT_MAX = (1 << CW) - 1;

   localparam logic [6:0] LOAD = 7'b0000011;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   instr = 32'h0;
   logic          instr_valid = 1'b0;
   logic          flush = 1'b0;
   logic          id_ex_regWrite = 1'b0;
   logic [RW-1:0] id_ex_rd = '0;
   logic          ld_done = 1'b0;
   logic [RW-1:0] ld_rd = '0;
   logic          stall, pcWrite, issue, err;
   logic [NR-1:0] busy_vec;
   logic [2:0]    outstanding;
   logic [CW-1:0] stall_cycles;

   scoreboard_hazard_unit #(
      .NUM_REGS(NR), .REG_W(RW), .MAX_OUTSTANDING(MO), .CNT_W(CW)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_instr_valid(instr_valid),
      .i_flush(flush), .i_id_ex_regWrite(id_ex_regWrite), .i_id_ex_rd(id_ex_rd),
      .i_ld_done(ld_done), .i_ld_rd(ld_rd),
      .o_stall(stall), .o_pcWrite(pcWrite), .o_issue(issue), .o_busy_vec(busy_vec),
      .o_outstanding(outstanding), .o_stall_cycles(stall_cycles), .o_err(err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit  m_busy[NR];
   int  m_out;
   int  m_cnt;
   bit  m_err;
   bit  e_stall, e_issue;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit reads_rs1(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                        7'b1100011, 7'b1100111, 7'b1110011};
   endfunction

   function automatic bit reads_rs2(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction

   function automatic bit pending(input int r);
      if (r == 0) return 1'b0;
      if (ld_done && int'(ld_rd) == r) return 1'b0;
      return m_busy[r];
   endfunction

   function automatic bit model_stall();
      logic [6:0] op;
      int s1, s2;
      bit u1, u2, load_use, br_raw, cap;
      op = instr[6:0];
      s1 = int'(instr[19:15]);
      s2 = int'(instr[24:20]);
      u1 = reads_rs1(op);
      u2 = reads_rs2(op);
      load_use = (u1 && pending(s1)) || (u2 && pending(s2));
      br_raw = (op == 7'b1100011 || op == 7'b1100111) && id_ex_regWrite &&
               id_ex_rd != 0 &&
               ((u1 && int'(id_ex_rd) == s1) || (u2 && int'(id_ex_rd) == s2));
      cap = (op == LOAD) && (m_out == MO) && !ld_done;
      return rst_n && instr_valid && !flush && (load_use || br_raw || cap);
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] v;
      v = '0;
      for (int r = 0; r < NR; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
      m_out = 0;
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   // Called at posedge+1; compares all outputs at posedge+4.
   task automatic settle();
      #3;
      e_stall = model_stall();
      e_issue = rst_n && instr_valid && !flush && !e_stall;
      chk("stall",        32'(stall),        32'(e_stall));
      chk("pcWrite",      32'(pcWrite),      32'(!e_stall));
      chk("issue",        32'(issue),        32'(e_issue));
      chk("busy_vec",     32'(busy_vec),     model_busy());
      chk("outstanding",  32'(outstanding),  32'(m_out));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
      chk("err",          32'(err),          32'(m_err));
   endtask

   // Advance across the clock edge and update the model from the rules.
   task automatic tick();
      @(posedge clk);
      if (ld_done) begin
         if (m_out == 0) m_err = 1'b1;
         else begin
            m_busy[ld_rd] = 1'b0;
            m_out--;
         end
      end
      if (e_issue && instr[6:0] == LOAD) begin
         if (instr[11:7] != 0) m_busy[instr[11:7]] = 1'b1;
         m_out++;
      end
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   // Asynchronous reset pulse between clock edges (caller is at posedge+4).
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("rst_busy",   32'(busy_vec),     32'h0);
      chk("rst_out",    32'(outstanding),  32'h0);
      chk("rst_cnt",    32'(stall_cycles), 32'h0);
      chk("rst_err",    32'(err),          32'h0);
      chk("rst_stall",  32'(stall),        32'h0);
      chk("rst_pcw",    32'(pcWrite),      32'h1);
      chk("rst_issue",  32'(issue),        32'h0);
      instr_valid = 1'b0;
      ld_done = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] r_add(input int rd, input int rs1, input int rs2);
      return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] i_lw(input int rd, input int rs1);
      return {12'h0, 5'(rs1), 3'b010, 5'(rd), LOAD};
   endfunction

   task automatic present(input logic [31:0] ins, input bit v, input bit done, input int drd);
      instr = ins;
      instr_valid = v;
      ld_done = done;
      ld_rd = RW'(drd);
   endtask

   logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1100111, 7'b1110011, 7'b0110111};

   initial begin
      model_clear();
      // Held in reset with a would-be hazard presented.
      instr = 32'h00418063;
      instr_valid = 1'b1;
      id_ex_regWrite = 1'b1;
      id_ex_rd = 5'd3;
      @(posedge clk);
      #4;
      chk("inrst_stall", 32'(stall),    32'h0);
      chk("inrst_pcw",   32'(pcWrite),  32'h1);
      chk("inrst_issue", 32'(issue),    32'h0);
      chk("inrst_busy",  32'(busy_vec), 32'h0);
      chk("inrst_out",   32'(outstanding), 32'h0);
      rst_n = 1'b1;
      id_ex_regWrite = 1'b0;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;

      // 1. Load-use hazard
      $display("T1 load-use");
      present(32'h0000A283, 1, 0, 0);           // lw x5,0(x1)
      settle(); chk("t1_lw_issue", 32'(issue), 32'h1); tick();
      present(r_add(6, 5, 2), 1, 0, 0);         // add x6,x5,x2
      for (int i = 0; i < 3; i++) begin
         settle(); chk("t1_stall", 32'(stall), 32'h1); tick();
      end
      present(r_add(6, 5, 2), 1, 1, 5);
      settle(); chk("t1_bypass_stall", 32'(stall), 32'h0);
      chk("t1_bypass_issue", 32'(issue), 32'h1); tick();
      present(32'h0, 0, 0, 0);
      settle(); chk("t1_busy5_clear", 32'(busy_vec[5]), 32'h0);
      chk("t1_stall_cycles", 32'(stall_cycles), 32'd3); tick();

      // 2. Independent instruction behind a load
      $display("T2 independent");
      present(32'h0000A283, 1, 0, 0); step();
      present(r_add(7, 1, 2), 1, 0, 0);
      settle(); chk("t2_stall", 32'(stall), 32'h0);
      chk("t2_issue", 32'(issue), 32'h1);
      chk("t2_out", 32'(outstanding), 32'd1); tick();
      present(32'h0, 0, 1, 5); step();

      // 3. Branch RAW
      $display("T3 branch RAW");
      id_ex_regWrite = 1'b1; id_ex_rd = 5'd3;
      present(32'h00418063, 1, 0, 0);           // beq x3,x4
      settle(); chk("t3_stall", 32'(stall), 32'h1);
      chk("t3_pcw", 32'(pcWrite), 32'h0); tick();
      present(r_add(8, 3, 4), 1, 0, 0);
      settle(); chk("t3_add_stall", 32'(stall), 32'h0); tick();
      id_ex_regWrite = 1'b0;

      // 4. Capacity
      $display("T4 capacity");
      present(i_lw(5, 1), 1, 0, 0); step();
      present(i_lw(6, 1), 1, 0, 0); step();
      present(i_lw(7, 1), 1, 0, 0);
      settle(); chk("t4_cap_stall", 32'(stall), 32'h1); tick();
      present(i_lw(7, 1), 1, 1, 5);
      settle(); chk("t4_stall", 32'(stall), 32'h0);
      chk("t4_issue", 32'(issue), 32'h1); tick();
      present(32'h0, 0, 0, 0);
      settle(); chk("t4_out", 32'(outstanding), 32'd2); tick();
      present(32'h0, 0, 1, 6); step();
      present(32'h0, 0, 1, 7); step();

      // 5. Corner cases
      $display("T5 corners");
      present(i_lw(0, 1), 1, 0, 0); step();
      present(32'h0, 0, 0, 0);
      settle(); chk("t5_x0_out", 32'(outstanding), 32'd1);
      chk("t5_x0_busy", 32'(busy_vec), 32'h0); tick();
      present(32'h0, 0, 1, 0); step();
      present(32'h0, 0, 1, 9); step();          // nothing outstanding
      present(32'h0, 0, 0, 0);
      settle(); chk("t5_err", 32'(err), 32'h1); tick();
      step(); step();
      settle(); chk("t5_err_sticky", 32'(err), 32'h1); tick();
      present(i_lw(5, 1), 1, 0, 0); step();
      flush = 1'b1;
      present(r_add(6, 5, 2), 1, 0, 0);
      settle(); chk("t5_flush_stall", 32'(stall), 32'h0);
      chk("t5_flush_issue", 32'(issue), 32'h0); tick();
      flush = 1'b0;
      present(32'h0, 0, 0, 0);
      settle(); chk("t5_flush_busy", 32'(busy_vec), 32'h0000_0020); tick();

      // 6. Async reset mid-operation
      $display("T6 async reset");
      present(i_lw(6, 1), 1, 0, 0); step();
      present(r_add(6, 5, 2), 1, 0, 0);
      settle(); chk("t6_pre_stall", 32'(stall), 32'h1);
      chk("t6_pre_out", 32'(outstanding), 32'd2);
      async_reset();

      // Randomized traffic
      $display("R random traffic");
      for (int n = 0; n < 3000; n++) begin
         instr = {7'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  3'b010, 5'($urandom_range(0, 7)), ops[$urandom_range(0, 7)]};
         instr_valid = ($urandom_range(0, 99) < 85);
         flush = ($urandom_range(0, 99) < 10);
         id_ex_regWrite = $urandom_range(0, 1) == 1;
         id_ex_rd = RW'($urandom_range(0, 7));
         ld_done = ($urandom_range(0, 99) < 35);
         ld_rd = RW'($urandom_range(0, 7));
         settle();
         if (n % 500 == 499) async_reset();
         else tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the combinational decode-stage hazard detector in the OTTER 5-stage pipeline, for a variable-latency data memory.
- Tracks pending load destinations in a per-register scoreboard and counts outstanding loads.
- Generates the stall and pcWrite signals for IF/ID, and the issue strobe into ID/EX.
- Keeps the branch/JALR RAW interlock, and adds a saturating stall-cycle performance counter and a sticky protocol-error flag.

Parameters:
- NUM_REGS, 32: architectural registers; must be a power of 2 and at most 32.
- REG_W, $clog2(NUM_REGS): register index width.
- MAX_OUTSTANDING, 2: maximum loads in flight; 1..7.
- CNT_W, 16: stall_cycles counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction held in IF/ID.
- instr_valid  in  1  IF/ID holds a real instruction.
- flush  in  1  taken branch/jump; kills IF/ID this cycle.
- id_ex_regWrite  in  1  instruction in EX writes a register.
- id_ex_rd  in  REG_W  EX destination.
- ld_done  in  1  a load's data is available to forward/writeback this cycle.
- ld_rd  in  REG_W  destination of the completing load.
- stall  out  1  hold PC and IF/ID.
- pcWrite  out  1  equals ~stall.
- issue  out  1  IF/ID instruction enters ID/EX this cycle.
- busy_vec  out  NUM_REGS  scoreboard, registered.
- outstanding  out  3  loads in flight, registered.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.
- err  out  1  sticky: ld_done seen with outstanding==0.

Behaviour:
- Reset (async, rst_n=0): busy_vec=0, outstanding=0, stall_cycles=0, err=0.
- While held in reset, stall=0, pcWrite=1 and issue=0, since the combinational outputs are gated by reset.
- Field decode: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], op=instr[6:0].
- use_rs1 is set when op is one of: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1110011.
- use_rs2 is set when op is one of: 0110011, 0100011, 1100011.
- Register 0 is never busy and never hazards.
- busy_eff[r] = busy_vec[r] & ~(ld_done & ld_rd==r). A load completing this cycle is bypassed and causes no stall.
- Stall sources; stall is the OR of all three, qualified by instr_valid & ~flush:
  - (a) Load-use: a used source register s has busy_eff[s].
  - (b) Branch/JALR RAW: op is 1100011 or 1100111, id_ex_regWrite=1, id_ex_rd!=0, and id_ex_rd equals a used source.
  - (c) Capacity: op=0000011 and outstanding==MAX_OUTSTANDING and ld_done=0.
- issue = instr_valid & ~flush & ~stall. Stall and issue are combinational, with the same cycle as instr.
- Load issue (issue & op==0000011):
  - On the next edge, busy_vec[rd] is set if rd!=0, and outstanding increments.
  - An rd==0 load still counts toward outstanding.
- ld_done:
  - On the next edge, busy_vec[ld_rd] is cleared and outstanding decrements.
  - Load issue and ld_done in the same cycle leave outstanding unchanged.
  - If the issuing load's rd equals ld_rd, set wins and busy stays 1.
  - ld_done with outstanding==0: no decrement, no busy change, err set to 1 until reset.
- A second load to an already-busy rd stalls through rule (a) only if it reads that register. Otherwise it issues and busy stays set; the scoreboard is a single bit, and memory completes loads in order.
- flush does not alter busy_vec or outstanding, because loads already in flight still complete.
- stall_cycles increments on each edge where stall=1, and saturates at all-ones.
- No other internal state exists. A reset mid-operation discards all in-flight tracking.

Test Plan:
1. Load-use hazard:
   - Stimulus: issue lw x5,0(x1) (0x0000A283); the next cycle present add x6,x5,x2 with ld_done=0 for 3 cycles, then ld_done=1, ld_rd=5.
   - Response: stall=1 for 3 cycles, then stall=0 and issue=1 on the ld_done cycle; busy_vec[5] clears after that edge; stall_cycles=3.
2. Independent instruction behind a load:
   - Stimulus: after lw x5, present add x7,x1,x2.
   - Response: stall=0, issue=1; outstanding=1.
3. Branch/JALR RAW hazard:
   - Stimulus: id_ex_regWrite=1, id_ex_rd=3, instr beq x3,x4 (0x00418063).
   - Response: stall=1, pcWrite=0.
   - Same inputs with add x8,x3,x4: stall=0.
4. Capacity limit (MAX_OUTSTANDING=2):
   - Stimulus: issue two loads (x5, x6); present a third load to x7 (rs1=x1).
   - Response: stall=1.
   - Then assert ld_done, ld_rd=5: stall=0, issue=1; outstanding stays 2.
5. Corner cases:
   - lw x0 issues: outstanding=1, busy_vec=0.
   - ld_done with outstanding=0: err=1 and stays 1.
   - flush=1 during a load-use stall: stall=0, issue=0, busy_vec unchanged.
6. Async reset mid-operation:
   - Stimulus: with busy_vec[5]=1, outstanding=2 and stall=1, pulse rst_n low between clock edges.
   - Response: all registered outputs are 0 immediately; stall=0, pcWrite=1.
